// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared types and constants for the binary-to-BCD converter.
//   state_t        : converter FSM states (IDLE, CONVERT, DONE)
//   bcd_digit_t    : one packed BCD nibble
//   ADD3_THRESHOLD : digit value at or above which double-dabble adds 3
//   bcd_ndigits()  : decimal digits needed to hold 2^w-1
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;

    // floor(w*log10(2)) + 1, using log10(2) ~= 0.30103; exact for w up to 64+.
    function automatic int bcd_ndigits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_converter_add3.sv
// bcd_add3 -- combinational double-dabble correction for one BCD digit.
//   d_i : digit before the shift
//   d_o : d_i + 3 when d_i >= ADD3_THRESHOLD, else d_i unchanged
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);

    assign d_o = (d_i >= ADD3_THRESHOLD) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bcd_converter.sv
// bcd_converter -- sequential binary-to-BCD converter (shift-and-add-3),
// one bit per clock, W iterations per conversion.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset
//   start    : conversion request, only looked at in IDLE
//   bin      : W-bit value, captured on the accepting edge
//   busy     : high in CONVERT and DONE
//   done     : one-cycle pulse when digits/overflow/sign update
//   digits   : NDIG BCD digits, digit 0 in [3:0]
//   overflow : result needs more than NDIG digits
//   sign     : result was negative (only with BCD_SIGN_EN, else tied 0)
//
// Build option: define BCD_SIGN_EN to treat bin as two's complement; the
// magnitude is converted and sign is registered alongside digits.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int W    = 32,
    parameter int NDIG = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic            busy,
    output logic            done,
    output logic [4*NDIG-1:0] digits,
    output logic            overflow,
    output logic            sign
);

    localparam int NBCD = bcd_ndigits(W);
    localparam int CW   = $clog2(W + 1);

    state_t              state_q, state_d;
    logic [W-1:0]        sr_q, sr_d;
    logic [4*NBCD-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*NDIG-1:0]   digits_q, digits_d;
    logic                ovf_q, ovf_d;

    logic [W-1:0]        load_val;
    logic [4*NBCD-1:0]   bcd_adj;
    logic [4*NBCD-1:0]   bcd_shift;
    logic [4*NDIG-1:0]   res_digits;
    logic                res_ovf;

    // ---- one add-3 cell per internal digit ----
    for (genvar g = 0; g < NBCD; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (bcd_q[4*g +: 4]),
            .d_o (bcd_adj[4*g +: 4])
        );
    end

    // Corrected BCD shifted left, taking the next binary MSB in at bit 0.
    assign bcd_shift = {bcd_adj[4*NBCD-2:0], sr_q[W-1]};

    // Low NDIG digits go out; anything above them flags overflow.
    if (NDIG <= NBCD) begin : g_res_trim
        assign res_digits = bcd_shift[4*NDIG-1:0];
    end else begin : g_res_pad
        assign res_digits = {{(4*(NDIG-NBCD)){1'b0}}, bcd_shift};
    end

    if (NBCD > NDIG) begin : g_ovf
        assign res_ovf = |bcd_shift[4*NBCD-1:4*NDIG];
    end else begin : g_no_ovf
        assign res_ovf = 1'b0;
    end

`ifdef BCD_SIGN_EN
    logic neg_q, neg_d;
    logic sign_q, sign_d;
    logic load_neg;

    assign load_neg = bin[W-1];
    // -2^(W-1) negates to itself, which is the right unsigned magnitude.
    assign load_val = load_neg ? -bin : bin;
    assign sign     = sign_q;
`else
    assign load_val = bin;
    assign sign     = 1'b0;
`endif

    // ---- next-state / datapath ----
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
`ifdef BCD_SIGN_EN
        neg_d    = neg_q;
        sign_d   = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = load_val;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
`ifdef BCD_SIGN_EN
                    neg_d   = load_neg;
`endif
                end
            end
            CONVERT: begin
                sr_d  = sr_q << 1;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + CW'(1);
                // Last iteration: publish the result of this very shift.
                if (cnt_q == CW'(W - 1)) begin
                    state_d  = DONE;
                    digits_d = res_digits;
                    ovf_d    = res_ovf;
`ifdef BCD_SIGN_EN
                    sign_d   = neg_q;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- state registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
`ifdef BCD_SIGN_EN
            neg_q    <= 1'b0;
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
`ifdef BCD_SIGN_EN
            neg_q    <= neg_d;
            sign_q   <= sign_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign digits   = digits_q;
    assign overflow = ovf_q;

endmodule

// File: doc/bcd_converter.md
BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 SHALL have parameter W, default 32, binary input width.
REQ-002 SHALL have parameter NDIG, default 8, number of BCD digits driven to the display stage.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, conversion request; sampled only in IDLE.
REQ-006 SHALL have port bin, input, W, value to convert; sampled on the accepting edge only.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when digits update.
REQ-009 SHALL have port digits, output, 4*NDIG, BCD result; digit 0 in bits [3:0].
REQ-010 SHALL have port overflow, output, 1, set when the result needs more than NDIG digits.
REQ-011 SHALL have port sign, output, 1, negative-result flag (see Configuration).

Function
REQ-012 SHALL implement the FSM IDLE -> CONVERT -> DONE -> IDLE.
REQ-013 IDLE with start=1 at edge E0 SHALL load bin into a shift register, clear the internal BCD register, clear the iteration counter and enter CONVERT.
REQ-014 Each CONVERT edge SHALL add 3 to every internal BCD digit >= 5, then shift {bcd, bin} left by one, as one iteration per cycle.
REQ-015 The internal BCD register SHALL hold enough digits for 2^W-1 (10 for W=32), and the counter SHALL be clog2(W+1) bits wide.
REQ-016 At edge E_W (the W-th iteration) the FSM SHALL move to DONE and register the low NDIG digits into digits, plus overflow = (any upper digit != 0).
REQ-017 done SHALL be high exactly in the cycle after E_W (latency W cycles from the accepting edge), and the FSM SHALL return to IDLE on the next edge.
REQ-018 busy SHALL be high in the CONVERT and DONE states and low in IDLE.
REQ-019 start in the CONVERT or DONE state SHALL be ignored, with no queuing; a held start SHALL begin a new conversion on the first IDLE edge.
REQ-020 digits, overflow and sign SHALL hold their last values until the next done.
REQ-021 Changes on bin after the accepting edge SHALL NOT affect the result.

Reset
REQ-022 reset low SHALL force IDLE, with busy=0, done=0, digits=0, overflow=0, sign=0 and the counter at 0, immediately and regardless of clk.
REQ-023 Reset during CONVERT SHALL abort the conversion, with no done pulse; the first start after release SHALL convert normally.

Configuration
REQ-024 With BCD_SIGN_EN defined, bin SHALL be treated as two's complement: a negative value converts its magnitude with sign=1 registered alongside digits, and -2^(W-1) converts to 2147483648 (overflow=1 for NDIG=8).
REQ-025 Without BCD_SIGN_EN, bin SHALL be unsigned, the sign port SHALL remain present and be tied to 0, and no negation logic SHALL be synthesized.

Structure
REQ-026 Package bcd_pkg SHALL hold the FSM state enum (IDLE, CONVERT, DONE), the bcd_digit_t nibble typedef and the ADD3_THRESHOLD=5 constant.
REQ-027 The per-digit conditional add-3 SHALL be a combinational sub-module, bcd_add3, instantiated once per internal digit.

Verification
REQ-028 bin=0, start pulse -> done exactly 32 cycles after the accepting edge, digits=0x00000000, overflow=0.
REQ-029 bin=12345678 -> digits=0x12345678, overflow=0; bin=99999999 -> digits=0x99999999, overflow=0; bin=100000000 -> digits=0x00000000, overflow=1.
REQ-030 Start bin=42, then pulse start with bin=7 at cycle 10 -> single done, digits=0x00000042, busy continuous.
REQ-031 Start bin=555, reset low at cycle 15 -> busy=0, digits=0 immediately, no done; then convert 42 after release -> digits=0x00000042.
REQ-032 bin=0xFFFFFFFF with BCD_SIGN_EN -> sign=1, digits=0x00000001; without BCD_SIGN_EN -> sign=0, digits=0x94967295, overflow=1.
REQ-033 Start held high continuously with bin=9 -> done every 34 cycles, digits=0x00000009 each time.
